// File: rtl/or1200_insn_seq.sv
// or1200_insn_seq: instruction-stream player for OR1200 custom-instruction bring-up.
// Plays a loadable {wait, insn} program onto if_insn, honouring id_freeze,
// and captures register-file write-back data into a show-ahead result FIFO.
// Optional feature macro: INSN_SEQ_LOOP_EN (replay the program loop_cnt extra times).
module or1200_insn_seq #(
    parameter int unsigned AW       = 6,
    parameter int unsigned WAIT_W   = 16,
    parameter int unsigned RES_AW   = 5,
    parameter logic [31:0] NOP_INSN = 32'h1500_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [31:0]       prog_insn,
    input  logic [WAIT_W-1:0] prog_wait,
    input  logic [AW:0]       prog_len,
    input  logic [7:0]        loop_cnt,
    input  logic              start,
    input  logic              stop,
    input  logic              id_freeze,
    output logic [31:0]       if_insn,
    output logic              insn_valid,
    output logic              busy,
    output logic              done,
    output logic [AW-1:0]     cur_ptr,
    input  logic              rf_we,
    input  logic [31:0]       rf_dataw,
    input  logic              res_rd,
    output logic [31:0]       res_data,
    output logic              res_empty,
    output logic              res_full,
    output logic              res_ovf
);

    localparam int unsigned DEPTH     = 1 << AW;
    localparam int unsigned RES_DEPTH = 1 << RES_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    // Program storage (not reset: contents survive rst_n)
    logic [31:0]       prog_insn_mem [DEPTH];
    logic [WAIT_W-1:0] prog_wait_mem [DEPTH];

    state_t            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [AW:0]       len_q, len_d;
    logic              start_acc;
    logic              playing;
    logic              last_entry;
    logic [AW:0]       len_sat;

`ifdef INSN_SEQ_LOOP_EN
    logic [7:0]        loops_q, loops_d;
`else
    logic              unused_loop_cnt;
    assign unused_loop_cnt = ^loop_cnt;
`endif

    // Output registers
    logic [31:0]       if_insn_q;
    logic              insn_valid_q;
    logic              busy_q;
    logic              done_q;
    logic [AW-1:0]     cur_ptr_q;

    // Result FIFO state; pointers carry one extra bit to tell full from empty
    logic [31:0]       res_mem [RES_DEPTH];
    logic [RES_AW:0]   wr_q, rd_q;
    logic              ovf_q;
    logic              push, pop, push_ok;

    assign playing    = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign last_entry = ({1'b0, ptr_q} == (len_q - 1'b1));
    assign len_sat    = (prog_len > (AW + 1)'(DEPTH)) ? (AW + 1)'(DEPTH) : prog_len;

    // Program memory write port, locked out during playback
    always_ff @(posedge clk) begin
        if (prog_we && !playing) begin
            prog_insn_mem[prog_addr] <= prog_insn;
            prog_wait_mem[prog_addr] <= prog_wait;
        end
    end

    // Next-state logic for the playback FSM; stop is applied last so it overrides all
    always_comb begin
        logic step;
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        start_acc = 1'b0;
        step      = 1'b0;
`ifdef INSN_SEQ_LOOP_EN
        loops_d   = loops_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (prog_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_ISSUE;
                        ptr_d     = '0;
                        cnt_d     = '0;
                        len_d     = len_sat;
                        start_acc = 1'b1;
`ifdef INSN_SEQ_LOOP_EN
                        loops_d   = loop_cnt;
`endif
                    end
                end
            end
            S_ISSUE: begin
                if (!id_freeze) begin
                    if (prog_wait_mem[ptr_q] == '0) begin
                        step = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = prog_wait_mem[ptr_q];
                    end
                end
            end
            S_WAIT: begin
                if (!id_freeze) begin
                    if (cnt_q == WAIT_W'(1)) begin
                        step = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Shared "advance to next entry" path for ISSUE (wait=0) and end of WAIT
        if (step) begin
            if (last_entry) begin
`ifdef INSN_SEQ_LOOP_EN
                if (loops_q != '0) begin
                    state_d = S_ISSUE;
                    ptr_d   = '0;
                    loops_d = loops_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end else begin
                state_d = S_ISSUE;
                ptr_d   = ptr_q + 1'b1;
            end
        end

        if (stop) begin
            state_d   = S_IDLE;
            start_acc = 1'b0;
        end
    end

    // FSM state registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef INSN_SEQ_LOOP_EN
            loops_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
`ifdef INSN_SEQ_LOOP_EN
            loops_q <= loops_d;
`endif
        end
    end

    // Registered outputs follow the current state one cycle later; stop forces them idle at once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_insn_q    <= NOP_INSN;
            insn_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_ptr_q    <= '0;
        end else begin
            if_insn_q    <= NOP_INSN;
            insn_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cur_ptr_q    <= ptr_q;
            if (!stop) begin
                case (state_q)
                    S_ISSUE: begin
                        if_insn_q    <= prog_insn_mem[ptr_q];
                        insn_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                    S_WAIT: begin
                        busy_q <= 1'b1;
                    end
                    S_DONE: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign if_insn    = if_insn_q;
    assign insn_valid = insn_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cur_ptr    = cur_ptr_q;

    // Result FIFO control: a full FIFO still accepts a push when a pop frees a slot
    assign res_empty = (wr_q == rd_q);
    assign res_full  = (wr_q[RES_AW] != rd_q[RES_AW]) &&
                       (wr_q[RES_AW-1:0] == rd_q[RES_AW-1:0]);
    assign push      = rf_we && (busy_q || done_q);
    assign pop       = res_rd && !res_empty;
    assign push_ok   = push && (!res_full || pop);
    assign res_data  = res_empty ? '0 : res_mem[rd_q[RES_AW-1:0]];
    assign res_ovf   = ovf_q;

    // FIFO data storage
    always_ff @(posedge clk) begin
        if (push_ok && !start_acc) begin
            res_mem[wr_q[RES_AW-1:0]] <= rf_dataw;
        end
    end

    // FIFO pointers and sticky overflow; an accepted start empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else if (start_acc) begin
            wr_q  <= '0;
            rd_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (push && res_full && !pop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_or1200_insn_seq.sv
// Bench for or1200_insn_seq: directed vector table, hand-written corner sequences,
// and randomized playback checked every cycle against a queue-based reference model.
module tb_or1200_insn_seq;

    localparam int unsigned AW     = 6;
    localparam int unsigned WAIT_W = 16;
    localparam int unsigned RES_AW = 5;
    localparam logic [31:0] NOP    = 32'h1500_0000;
    localparam int          DEPTH  = 64;
    localparam int          RDEPTH = 32;
`ifdef INSN_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, prog_we, start, stop, id_freeze, rf_we, res_rd;
    logic [AW-1:0]     prog_addr;
    logic [31:0]       prog_insn, rf_dataw;
    logic [WAIT_W-1:0] prog_wait;
    logic [AW:0]       prog_len;
    logic [7:0]        loop_cnt;
    logic [31:0]       if_insn, res_data;
    logic              insn_valid, busy, done, res_empty, res_full, res_ovf;
    logic [AW-1:0]     cur_ptr;

    always #5 clk = ~clk;

    or1200_insn_seq #(
        .AW(AW), .WAIT_W(WAIT_W), .RES_AW(RES_AW), .NOP_INSN(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_insn(prog_insn), .prog_wait(prog_wait), .prog_len(prog_len),
        .loop_cnt(loop_cnt), .start(start), .stop(stop), .id_freeze(id_freeze),
        .if_insn(if_insn), .insn_valid(insn_valid), .busy(busy), .done(done),
        .cur_ptr(cur_ptr), .rf_we(rf_we), .rf_dataw(rf_dataw), .res_rd(res_rd),
        .res_data(res_data), .res_empty(res_empty), .res_full(res_full),
        .res_ovf(res_ovf)
    );

    // ---------------- reference model ----------------
    // Playback is a queue of one-cycle "slots" built at start: one issue slot per
    // entry, `wait` NOP slots after it, then a done slot. A frozen cycle repeats the
    // head slot; outputs show the head slot one cycle later.
    typedef struct {
        logic [31:0] insn;
        bit          valid;
        bit          dn;
        int          ptr;
    } slot_t;

    slot_t       sq[$];
    logic [31:0] m_insn [DEPTH];
    int          m_wait [DEPTH];
    logic [31:0] fq[$];
    bit          m_ovf;
    logic [31:0] e_insn;
    bit          e_valid, e_busy, e_done;
    int          e_ptr;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_program(input int plen, input int lcnt);
        int len, passes;
        slot_t s;
        len    = (plen > DEPTH) ? DEPTH : plen;
        passes = LOOP_EN ? lcnt + 1 : 1;
        for (int p = 0; p < passes && len > 0; p++) begin
            for (int i = 0; i < len; i++) begin
                s = '{insn: m_insn[i], valid: 1'b1, dn: 1'b0, ptr: i};
                sq.push_back(s);
                for (int w = 0; w < m_wait[i]; w++) begin
                    s = '{insn: NOP, valid: 1'b0, dn: 1'b0, ptr: i};
                    sq.push_back(s);
                end
            end
        end
        s = '{insn: NOP, valid: 1'b0, dn: 1'b1, ptr: 0};
        sq.push_back(s);
    endtask

    task automatic model_edge();
        bit playing, accept, push, pop;
        if (!rst_n) begin
            sq.delete();
            fq.delete();
            m_ovf = 0; e_insn = NOP; e_valid = 0; e_busy = 0; e_done = 0; e_ptr = 0;
            return;
        end
        playing = (sq.size() > 0) && !sq[0].dn;
        if (prog_we && !playing) begin
            m_insn[prog_addr] = prog_insn;
            m_wait[prog_addr] = int'(prog_wait);
        end
        accept = (sq.size() == 0) && start && !stop && (prog_len != 0);
        push   = rf_we && (e_busy || e_done);
        pop    = res_rd && (fq.size() > 0);
        if (accept) begin
            fq.delete();
            m_ovf = 0;
        end else begin
            if (push && fq.size() == RDEPTH && !pop) m_ovf = 1;
            if (pop) void'(fq.pop_front());
            if (push && fq.size() < RDEPTH) fq.push_back(rf_dataw);
        end
        e_insn = NOP; e_valid = 0; e_busy = 0; e_done = 0;
        if (!stop && sq.size() > 0) begin
            e_insn  = sq[0].insn;
            e_valid = sq[0].valid;
            e_busy  = !sq[0].dn;
            e_done  = sq[0].dn;
            e_ptr   = sq[0].ptr;
        end
        if (stop) begin
            sq.delete();
        end else if (sq.size() > 0) begin
            if (sq[0].dn || !id_freeze) void'(sq.pop_front());
        end else if (start) begin
            build_program(int'(prog_len), int'(loop_cnt));
        end
    endtask

    task automatic compare_all();
        chk("if_insn", if_insn, e_insn);
        chk("insn_valid", 32'(insn_valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        if (e_busy) chk("cur_ptr", 32'(cur_ptr), 32'(e_ptr));
        chk("res_empty", 32'(res_empty), 32'(fq.size() == 0));
        chk("res_full", 32'(res_full), 32'(fq.size() == RDEPTH));
        chk("res_ovf", 32'(res_ovf), 32'(m_ovf));
        chk("res_data", res_data, (fq.size() > 0) ? fq[0] : 32'h0);
    endtask

    // One clock: model advances on the edge, DUT outputs are checked on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic load(input int addr, input logic [31:0] insn, input int wt);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_insn = insn;
        prog_wait = WAIT_W'(wt);
        cycle();
        prog_we   = 1'b0;
    endtask

    task automatic do_start(input int len, input int lc);
        prog_len = (AW + 1)'(len);
        loop_cnt = 8'(lc);
        start    = 1'b1;
        cycle();
        start    = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] i0, i1, i2;
        int          w0, w1, w2;
        int          len, loops, fz_at, fz_len;
        int          exp_valid, exp_busy;   // per pass
    } vec_t;

    vec_t vecs[7];

    initial begin
        int vc, bc, dc, k, passes, cnt;
        bit seen;

        vecs[0] = '{32'h9C20_0001, 32'h9C40_0002, 32'h9C60_0003, 0, 0, 0, 3, 0, -1, 0, 3, 3};
        vecs[1] = '{32'hF200_0004, NOP, NOP, 50, 0, 0, 1, 0, -1, 0, 1, 51};
        vecs[2] = '{32'h9C20_0001, 32'h9C40_0002, 32'h9C60_0003, 0, 0, 0, 3, 0, 1, 4, 7, 7};
        vecs[3] = '{32'hF200_0004, NOP, NOP, 10, 0, 0, 1, 0, 3, 3, 1, 14};
        vecs[4] = '{32'h9C20_0001, NOP, NOP, 0, 0, 0, 0, 0, -1, 0, 0, 0};
        vecs[5] = '{32'hA000_000A, 32'hB000_000B, NOP, 0, 0, 0, 2, 2, -1, 0, 2, 2};
        vecs[6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 1, 2, 0, 3, 0, 2, 2, 5, 8};

        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_insn = '0; prog_wait = '0;
        prog_len = '0; loop_cnt = '0; start = 1'b0; stop = 1'b0; id_freeze = 1'b0;
        rf_we = 1'b0; rf_dataw = '0; res_rd = 1'b0;

        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_if_insn", if_insn, NOP);
        chk("rst_flags", {27'h0, insn_valid, busy, done, res_ovf, res_full}, 32'h0);
        chk("rst_cur_ptr", 32'(cur_ptr), 32'h0);
        chk("rst_res_empty", 32'(res_empty), 32'h1);
        chk("rst_res_data", res_data, 32'h0);
        cycle();

        foreach (vecs[v]) begin
            load(0, vecs[v].i0, vecs[v].w0);
            load(1, vecs[v].i1, vecs[v].w1);
            load(2, vecs[v].i2, vecs[v].w2);
            do_start(vecs[v].len, vecs[v].loops);
            vc = 0; bc = 0; dc = 0; seen = 0;
            for (k = 0; k < 400 && !seen; k++) begin
                id_freeze = (k >= vecs[v].fz_at) && (k < vecs[v].fz_at + vecs[v].fz_len);
                cycle();
                vc += int'(insn_valid);
                bc += int'(busy);
                dc += int'(done);
                seen = done;
            end
            id_freeze = 1'b0;
            if (!seen) chk($sformatf("vec%0d_timeout", v), 32'h0, 32'h1);
            passes = LOOP_EN ? vecs[v].loops + 1 : 1;
            chk($sformatf("vec%0d_valid_cycles", v), 32'(vc), 32'(vecs[v].exp_valid * passes));
            chk($sformatf("vec%0d_busy_cycles", v), 32'(bc), 32'(vecs[v].exp_busy * passes));
            chk($sformatf("vec%0d_done_pulses", v), 32'(dc), 32'h1);
            cycle();
            chk($sformatf("vec%0d_done_one_cycle", v), 32'(done), 32'h0);
        end

        // stop in the middle of WAIT: idle next cycle, no done pulse
        load(0, 32'hF200_0004, 20);
        do_start(1, 0);
        repeat (5) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        dc = 0;
        repeat (25) begin cycle(); dc += int'(done); end
        chk("stop_no_done", 32'(dc), 32'h0);

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1; prog_len = 7'd1;
        cycle();
        start = 1'b0; stop = 1'b0;
        cycle();
        chk("start_stop_busy", 32'(busy), 32'h0);
        cycle();

        // reset mid-playback: no done pulse; program memory survives
        do_start(1, 0);
        repeat (3) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        dc = 0;
        repeat (25) begin cycle(); dc += int'(done); end
        chk("reset_no_done", 32'(dc), 32'h0);
        load(1, 32'h9C40_0002, 0);
        do_start(2, 0);
        cycle();
        chk("kept_insn0", if_insn, 32'hF200_0004);

        // 40 pushes into a 32-deep FIFO while busy, then drain
        stop = 1'b1; cycle(); stop = 1'b0;
        load(0, 32'hF200_0004, 100);
        do_start(1, 0);
        cnt = 0;
        while (!busy && cnt < 10) begin cycle(); cnt++; end
        if (!busy) chk("fifo_busy_timeout", 32'h0, 32'h1);
        for (int i = 0; i < 40; i++) begin
            rf_we = 1'b1; rf_dataw = 32'hD000_0000 + 32'(i);
            cycle();
        end
        rf_we = 1'b0;
        chk("fifo_full", 32'(res_full), 32'h1);
        chk("fifo_ovf", 32'(res_ovf), 32'h1);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("fifo_pop%0d", i), res_data, 32'hD000_0000 + 32'(i));
            res_rd = 1'b1;
            cycle();
        end
        res_rd = 1'b0;
        chk("fifo_drained", 32'(res_empty), 32'h1);
        res_rd = 1'b1; cycle(); res_rd = 1'b0;
        chk("fifo_pop_empty", res_data, 32'h0);
        stop = 1'b1; cycle(); stop = 1'b0;

        // prog_len larger than the program depth saturates to DEPTH entries
        for (int i = 0; i < DEPTH; i++) load(i, $urandom, 0);
        do_start(100, 0);
        vc = 0; seen = 0;
        for (k = 0; k < 300 && !seen; k++) begin
            cycle();
            vc += int'(insn_valid);
            seen = done;
        end
        chk("saturate_issues", 32'(vc), 32'(DEPTH));

        // randomized playback against the model
        for (int r = 0; r < 25; r++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) load(i, $urandom, int'($urandom_range(0, 3)));
            do_start(int'($urandom_range(0, 8)), int'($urandom_range(0, 2)));
            for (k = 0; k < 400 && sq.size() > 0; k++) begin
                id_freeze = ($urandom_range(0, 3) == 0);
                rf_we     = $urandom_range(0, 1) == 1;
                rf_dataw  = $urandom;
                res_rd    = ($urandom_range(0, 3) == 0);
                stop      = ($urandom_range(0, 63) == 0);
                prog_we   = ($urandom_range(0, 7) == 0);
                prog_addr = AW'($urandom_range(0, 7));
                prog_insn = $urandom;
                prog_wait = WAIT_W'($urandom_range(0, 3));
                cycle();
            end
            if (sq.size() > 0) chk("random_timeout", 32'h0, 32'h1);
            id_freeze = 1'b0; rf_we = 1'b0; res_rd = 1'b0; stop = 1'b0; prog_we = 1'b0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
